// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - shared scancodes, key indices and coin FSM states for arcade input conditioning
package arcade_input_pkg;

    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_1      = 8'h16;
    localparam logic [7:0] SC_F2     = 8'h06;
    localparam logic [7:0] SC_2      = 8'h1E;
    localparam logic [7:0] SC_5      = 8'h2E;
    localparam logic [7:0] SC_6      = 8'h36;

    localparam int CTRL_RIGHT = 0;
    localparam int CTRL_LEFT  = 1;
    localparam int CTRL_DOWN  = 2;
    localparam int CTRL_UP    = 3;
    localparam int CTRL_FIRE  = 4;
    localparam int CTRL_W     = 5;

    typedef enum logic [4:0] {
        K_P1_RIGHT, K_P1_LEFT, K_P1_DOWN, K_P1_UP, K_P1_SPACE, K_P1_CTRL,
        K_P2_D, K_P2_A, K_P2_S, K_P2_W, K_P2_LSHIFT,
        K_F1, K_ONE, K_F2, K_TWO, K_FIVE, K_SIX
    } key_idx_e;

    localparam int NUM_KEYS = 17;

    typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT_REL} coin_state_t;

    // Arrow keys arrive with or without the E0 prefix; everything else must be a plain code.
    function automatic logic [NUM_KEYS-1:0] key_decode(input logic [7:0] code, input logic ext);
        logic [NUM_KEYS-1:0] hit;
        hit = '0;
        case (code)
            SC_RIGHT:  hit[K_P1_RIGHT]  = 1'b1;
            SC_LEFT:   hit[K_P1_LEFT]   = 1'b1;
            SC_DOWN:   hit[K_P1_DOWN]   = 1'b1;
            SC_UP:     hit[K_P1_UP]     = 1'b1;
            SC_SPACE:  hit[K_P1_SPACE]  = ~ext;
            SC_LCTRL:  hit[K_P1_CTRL]   = ~ext;
            SC_D:      hit[K_P2_D]      = ~ext;
            SC_A:      hit[K_P2_A]      = ~ext;
            SC_S:      hit[K_P2_S]      = ~ext;
            SC_W:      hit[K_P2_W]      = ~ext;
            SC_LSHIFT: hit[K_P2_LSHIFT] = ~ext;
            SC_F1:     hit[K_F1]        = ~ext;
            SC_1:      hit[K_ONE]       = ~ext;
            SC_F2:     hit[K_F2]        = ~ext;
            SC_2:      hit[K_TWO]       = ~ext;
            SC_5:      hit[K_FIVE]      = ~ext;
            SC_6:      hit[K_SIX]       = ~ext;
            default:   hit = '0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/coin_pulse_gen.sv
// rtl/coin_pulse_gen.sv - shapes a raw coin level into one fixed-width pulse followed by a lockout gap
module coin_pulse_gen #(
    parameter int unsigned COIN_PULSE_CYC = 4800000,
    parameter int unsigned COIN_GAP_CYC   = 2400000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic coin_raw,
    output logic coin1,
    output logic coin_busy
);
    import arcade_input_pkg::*;

    localparam int unsigned MAX_CYC = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP_CYC - 1);

    coin_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             raw_q, prev_q, rise;
    logic             coin1_q, busy_q;

    assign rise = raw_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = raw_q ? WAIT_REL : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                if (!raw_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The edge detector tracks the input through reset so a coin held across reset needs a fresh rise.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            raw_q   <= coin_raw;
            prev_q  <= coin_raw;
            state_q <= IDLE;
            cnt_q   <= '0;
            coin1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            raw_q   <= coin_raw;
            prev_q  <= raw_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coin1_q <= (state_d == PULSE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign coin1     = coin1_q;
    assign coin_busy = busy_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// rtl/arcade_input_ctrl.sv - ps2 key decode merged with joysticks into registered game-core controls
module arcade_input_ctrl #(
    parameter int unsigned COIN_PULSE_CYC = 4800000,
    parameter int unsigned COIN_GAP_CYC   = 2400000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic [4:0]  p1_ctrl,
    output logic [4:0]  p2_ctrl,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        coin_busy
);
    import arcade_input_pkg::*;

    logic                old_toggle_q;
    logic                evt;
    logic [NUM_KEYS-1:0] key_hit;
    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic [CTRL_W-1:0]   p1_key, p2_key;
    logic [CTRL_W-1:0]   p1_q, p1_d, p2_q, p2_d;
    logic                start1_q, start1_d, start2_q, start2_d;
    logic                coin_raw;
    logic                unused_joy;

    assign unused_joy = ^{joystick_0[15:8], joystick_1[15:8], joystick_1[6]};

    always_comb begin
        evt     = ps2_key[10] ^ old_toggle_q;
        key_hit = key_decode(ps2_key[7:0], ps2_key[8]);
        keys_d  = keys_q;
        if (evt) keys_d = (keys_q & ~key_hit) | (key_hit & {NUM_KEYS{ps2_key[9]}});
    end

    always_comb begin
        p1_key = '0;
        p2_key = '0;
        p1_key[CTRL_RIGHT] = keys_q[K_P1_RIGHT];
        p1_key[CTRL_LEFT]  = keys_q[K_P1_LEFT];
        p1_key[CTRL_DOWN]  = keys_q[K_P1_DOWN];
        p1_key[CTRL_UP]    = keys_q[K_P1_UP];
        p1_key[CTRL_FIRE]  = keys_q[K_P1_SPACE] | keys_q[K_P1_CTRL];
        p2_key[CTRL_RIGHT] = keys_q[K_P2_D];
        p2_key[CTRL_LEFT]  = keys_q[K_P2_A];
        p2_key[CTRL_DOWN]  = keys_q[K_P2_S];
        p2_key[CTRL_UP]    = keys_q[K_P2_W];
        p2_key[CTRL_FIRE]  = keys_q[K_P2_LSHIFT];
        p1_d     = p1_key | joystick_0[4:0];
        p2_d     = p2_key | joystick_1[4:0];
        start1_d = keys_q[K_F1] | keys_q[K_ONE] | joystick_0[5];
        start2_d = keys_q[K_F2] | keys_q[K_TWO] | joystick_0[6] | joystick_1[5];
        coin_raw = keys_q[K_FIVE] | keys_q[K_SIX] | joystick_0[7] | joystick_1[7];
    end

    // Capturing the toggle bit during reset keeps a stale toggle from looking like an event.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            old_toggle_q <= ps2_key[10];
            keys_q       <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            start1_q     <= 1'b0;
            start2_q     <= 1'b0;
        end else begin
            old_toggle_q <= ps2_key[10];
            keys_q       <= keys_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            start1_q     <= start1_d;
            start2_q     <= start2_d;
        end
    end

    assign p1_ctrl = p1_q;
    assign p2_ctrl = p2_q;
    assign start1  = start1_q;
    assign start2  = start2_q;

    coin_pulse_gen #(
        .COIN_PULSE_CYC (COIN_PULSE_CYC),
        .COIN_GAP_CYC   (COIN_GAP_CYC)
    ) u_coin (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .coin_raw  (coin_raw),
        .coin1     (coin1),
        .coin_busy (coin_busy)
    );

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// tb/tb_arcade_input_ctrl.sv - directed scoreboard bench for arcade_input_ctrl
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic [4:0]  p1_ctrl, p2_ctrl;
    logic        start1, start2, coin1, coin_busy;
    logic [13:0] obs;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [13:0] M_P1  = 14'h3E00;
    localparam logic [13:0] M_P2  = 14'h01F0;
    localparam logic [13:0] M_S1  = 14'h0008;
    localparam logic [13:0] M_S2  = 14'h0004;
    localparam logic [13:0] M_C1  = 14'h0002;
    localparam logic [13:0] M_BZ  = 14'h0001;
    localparam logic [13:0] M_ALL = 14'h3FFF;

    typedef struct { string tag; logic [13:0] mask; logic [13:0] val; } out_exp_t;
    typedef struct { string tag; int val; } cnt_exp_t;
    out_exp_t out_q[$];
    cnt_exp_t cnt_q[$];

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl #(.COIN_PULSE_CYC(8), .COIN_GAP_CYC(4)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .p1_ctrl    (p1_ctrl),
        .p2_ctrl    (p2_ctrl),
        .start1     (start1),
        .start2     (start2),
        .coin1      (coin1),
        .coin_busy  (coin_busy)
    );

    assign obs = {p1_ctrl, p2_ctrl, start1, start2, coin1, coin_busy};

    function automatic logic [13:0] v_p1(input logic [4:0] x);
        return {x, 9'b0};
    endfunction

    function automatic logic [13:0] v_p2(input logic [4:0] x);
        return {5'b0, x, 4'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic exp_out(input string tag, input logic [13:0] mask, input logic [13:0] val);
        out_exp_t e;
        e.tag = tag; e.mask = mask; e.val = val;
        out_q.push_back(e);
    endtask

    task automatic check_out();
        out_exp_t e;
        e = out_q.pop_front();
        n_cmp++;
        assert ((obs & e.mask) === (e.val & e.mask)) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (mask %h)", e.tag, obs & e.mask, e.val & e.mask, e.mask);
        end
    endtask

    task automatic check_cnt(input int got);
        cnt_exp_t e;
        e = cnt_q.pop_front();
        n_cmp++;
        assert (got === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, got, e.val);
        end
    endtask

    task automatic push_cnt(input string tag, input int val);
        cnt_exp_t e;
        e.tag = tag; e.val = val;
        cnt_q.push_back(e);
    endtask

    // Sample i is taken i edges after the call; coin lines are driven from the injection patterns.
    task automatic coin_window(input string tag, input int n, input logic [63:0] inj0, input logic [63:0] inj1,
                               input int exp_hi, input int exp_bz, input int exp_rises, input int exp_first);
        int hi, bz, rises, first;
        logic prev;
        hi = 0; bz = 0; rises = 0; first = -1; prev = 1'b0;
        push_cnt({tag, "_high_cycles"}, exp_hi);
        push_cnt({tag, "_busy_cycles"}, exp_bz);
        push_cnt({tag, "_pulses"}, exp_rises);
        push_cnt({tag, "_first_high"}, exp_first);
        for (int i = 0; i < n; i++) begin
            joystick_0[7] = inj0[i];
            joystick_1[7] = inj1[i];
            if (coin1) hi++;
            if (coin_busy) bz++;
            if (coin1 && !prev) begin
                rises++;
                if (first < 0) first = i;
            end
            prev = coin1;
            tick(1);
        end
        check_cnt(hi);
        check_cnt(bz);
        check_cnt(rises);
        check_cnt(first);
    endtask

    initial begin
        reset_n    = 1'b0;
        ps2_key    = '0;
        joystick_0 = '0;
        joystick_1 = '0;
        exp_out("reset_all_zero", M_ALL, 14'h0);
        tick(3);
        check_out();
        reset_n = 1'b1;
        tick(1);

        ps2(1'b1, 1'b0, 8'h75);
        exp_out("up_press_edge1", M_P1, v_p1(5'b00000));
        exp_out("up_press_edge2", M_P1, v_p1(5'b01000));
        tick(1); check_out();
        tick(1); check_out();
        ps2(1'b0, 1'b0, 8'h75);
        exp_out("up_release", M_P1, v_p1(5'b00000));
        tick(2); check_out();

        ps2(1'b1, 1'b0, 8'h75); tick(1);
        ps2(1'b1, 1'b0, 8'h1D);
        exp_out("p1_up_p2_up", M_P1 | M_P2, v_p1(5'b01000) | v_p2(5'b01000));
        tick(2); check_out();
        ps2(1'b0, 1'b0, 8'h75); tick(1);
        ps2(1'b0, 1'b0, 8'h1D);
        exp_out("both_up_released", M_ALL, 14'h0);
        tick(2); check_out();

        ps2(1'b1, 1'b0, 8'h29); tick(1);
        ps2(1'b1, 1'b0, 8'h14);
        exp_out("fire_space_ctrl", M_P1, v_p1(5'b10000));
        tick(2); check_out();
        ps2(1'b0, 1'b0, 8'h29);
        exp_out("fire_ctrl_still_held", M_P1, v_p1(5'b10000));
        tick(2); check_out();
        ps2(1'b0, 1'b0, 8'h14);
        exp_out("fire_all_released", M_P1, v_p1(5'b00000));
        tick(2); check_out();

        ps2(1'b1, 1'b1, 8'h29);
        exp_out("extended_space_ignored", M_ALL, 14'h0);
        tick(2); check_out();
        ps2(1'b1, 1'b1, 8'h74);
        exp_out("extended_right_arrow", M_P1, v_p1(5'b00001));
        tick(2); check_out();
        ps2(1'b0, 1'b1, 8'h74);
        exp_out("release_unheld_and_unmapped", M_ALL, 14'h0);
        tick(1);
        ps2(1'b0, 1'b0, 8'h1C); tick(1);
        ps2(1'b1, 1'b0, 8'h44);
        tick(2); check_out();

        joystick_0[4:0] = 5'b10101;
        joystick_1[5:0] = 6'b101010;
        exp_out("joy_one_edge", M_ALL, v_p1(5'b10101) | v_p2(5'b01010) | M_S2);
        tick(1); check_out();
        joystick_0 = 16'hFF60;
        joystick_1 = 16'hFF40;
        exp_out("joy_starts_high_bits", M_ALL, M_S1 | M_S2);
        tick(1); check_out();
        joystick_0 = '0;
        joystick_1 = '0;

        ps2(1'b1, 1'b0, 8'h05);
        joystick_0[0] = 1'b1;
        exp_out("simul_joy_first", M_P1 | M_S1, v_p1(5'b00001));
        exp_out("simul_key_second", M_P1 | M_S1, v_p1(5'b00001) | M_S1);
        tick(1); check_out();
        tick(1); check_out();
        joystick_0[0] = 1'b0;
        ps2(1'b0, 1'b0, 8'h05); tick(1);
        ps2(1'b1, 1'b0, 8'h1E);
        exp_out("start2_key_two", M_ALL, M_S2);
        tick(2); check_out();
        ps2(1'b0, 1'b0, 8'h1E);
        exp_out("start2_released", M_ALL, 14'h0);
        tick(2); check_out();

        coin_window("coin_single", 30, 64'h1, 64'h0, 8, 12, 1, 2);
        coin_window("coin_triple", 30, 64'h409, 64'h0, 8, 12, 1, 2);
        coin_window("coin_held", 48, 64'h0, 64'h00FF_FFFF_FFFF, 8, 40, 1, 2);
        coin_window("coin_second", 30, 64'h0, 64'h1, 8, 12, 1, 2);

        ps2(1'b1, 1'b0, 8'h2E);
        coin_window("coin_key5", 20, 64'h0, 64'h0, 8, 17, 1, 3);
        ps2(1'b0, 1'b0, 8'h2E);
        exp_out("coin_key5_released", M_C1 | M_BZ, 14'h0);
        tick(3); check_out();

        ps2(1'b1, 1'b0, 8'h29);
        tick(2);
        joystick_0[7] = 1'b1;
        exp_out("pulse_before_reset", M_P1 | M_C1 | M_BZ, v_p1(5'b10000) | M_C1 | M_BZ);
        tick(6); check_out();
        reset_n = 1'b0;
        ps2(1'b1, 1'b0, 8'h75);
        exp_out("reset_mid_pulse", M_ALL, 14'h0);
        tick(1); check_out();
        tick(2);
        reset_n = 1'b1;
        exp_out("after_reset_no_key_no_coin", M_ALL, 14'h0);
        tick(4); check_out();
        coin_window("coin_fresh_rise", 30, 64'h4, 64'h0, 8, 12, 1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
